// File: rtl/pipe_ma_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ma_pkg
// Shared constants for the memory-access stage and its neighbours:
//   - load/store enable encodings (RW_*)
//   - access length encodings (LEN_*)
//   - ALU opcode width (shared with the execute stage)
//   - memory-access FSM state type
//   - access_fault(): flags illegal encodings and misaligned accesses
// -----------------------------------------------------------------------------
package pipe_ma_pkg;

    localparam int ALUOP_W = 4;

    localparam logic [1:0] RW_NONE  = 2'b00;
    localparam logic [1:0] RW_LOAD  = 2'b01;
    localparam logic [1:0] RW_STORE = 2'b10;
    localparam logic [1:0] RW_ILL   = 2'b11;

    localparam logic [1:0] LEN_B    = 2'b00;
    localparam logic [1:0] LEN_H    = 2'b01;
    localparam logic [1:0] LEN_W    = 2'b10;
    localparam logic [1:0] LEN_ILL  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MEM  = 1'b1
    } ma_state_e;

    // A request is faulty if either encoding is illegal or the address is not
    // naturally aligned for its length. Non-memory instructions never fault.
    function automatic logic access_fault(input logic [1:0] rw_e,
                                          input logic [1:0] rw_len,
                                          input logic [1:0] addr_lo);
        logic fault;
        case (rw_e)
            RW_NONE: fault = 1'b0;
            RW_LOAD, RW_STORE: begin
                case (rw_len)
                    LEN_B:   fault = 1'b0;
                    LEN_H:   fault = addr_lo[0];
                    LEN_W:   fault = (addr_lo != 2'b00);
                    default: fault = 1'b1;
                endcase
            end
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/pipe_ma_lane.sv
// -----------------------------------------------------------------------------
// ma_lane
// Purely combinational byte-lane helper for the memory-access stage.
//   Store side: replicates store data across all lanes and produces the
//               little-endian byte-enable mask.
//   Load side:  extracts the addressed byte/half/word from the read word and
//               sign- or zero-extends it to REG_SZ.
// Ports:
//   addr_lo_i  [1:0]       byte offset within the word
//   len_i      [1:0]       access length (LEN_B/H/W)
//   uns_i                  1 = zero-extend load
//   st_data_i  [31:0]      store data from EX
//   ld_rdata_i [31:0]      raw memory read word
//   wdata_o    [31:0]      lane-replicated store data
//   wmask_o    [3:0]       byte-lane enables
//   ld_val_o   [REG_SZ-1:0] extended load result
// REG_SZ is expected to be at least 32.
// -----------------------------------------------------------------------------
module ma_lane
    import pipe_ma_pkg::*;
#(
    parameter int REG_SZ = 32
) (
    input  logic [1:0]        addr_lo_i,
    input  logic [1:0]        len_i,
    input  logic              uns_i,
    input  logic [31:0]       st_data_i,
    input  logic [31:0]       ld_rdata_i,
    output logic [31:0]       wdata_o,
    output logic [3:0]        wmask_o,
    output logic [REG_SZ-1:0] ld_val_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and half-word out of the read word.
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo_i)
            2'd0:    byte_s = ld_rdata_i[7:0];
            2'd1:    byte_s = ld_rdata_i[15:8];
            2'd2:    byte_s = ld_rdata_i[23:16];
            2'd3:    byte_s = ld_rdata_i[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo_i[1]) begin
            half_s = ld_rdata_i[31:16];
        end else begin
            half_s = ld_rdata_i[15:0];
        end
    end

    // Store-lane replication/mask and load extension by access length.
    always_comb begin
        wdata_o  = st_data_i;
        wmask_o  = 4'b0000;
        ld_val_o = '0;
        case (len_i)
            LEN_B: begin
                wdata_o = {4{st_data_i[7:0]}};
                wmask_o = 4'b0001 << addr_lo_i;
                if (uns_i) begin
                    ld_val_o = REG_SZ'(byte_s);
                end else begin
                    ld_val_o = REG_SZ'($signed(byte_s));
                end
            end
            LEN_H: begin
                wdata_o = {2{st_data_i[15:0]}};
                if (addr_lo_i[1]) begin
                    wmask_o = 4'b1100;
                end else begin
                    wmask_o = 4'b0011;
                end
                if (uns_i) begin
                    ld_val_o = REG_SZ'(half_s);
                end else begin
                    ld_val_o = REG_SZ'($signed(half_s));
                end
            end
            LEN_W: begin
                wdata_o = st_data_i;
                wmask_o = 4'b1111;
                if (uns_i) begin
                    ld_val_o = REG_SZ'(ld_rdata_i);
                end else begin
                    ld_val_o = REG_SZ'($signed(ld_rdata_i));
                end
            end
            default: begin
                wdata_o  = st_data_i;
                wmask_o  = 4'b0000;
                ld_val_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/pipe_ma.sv
// -----------------------------------------------------------------------------
// pipe_ma
// Memory-access pipeline stage between execute and write-back.
// Accepts one EX result per in_valid/in_ready handshake, performs at most one
// load or store over a single-outstanding req/ack memory port, and holds the
// final write-back value in an output register that is also forwarded to EX.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid/in_ready            EX handshake
//   pc_in, ans_in, dat_in        PC, ALU result / address, store data
//   rw_e_in, rw_len_in, ld_uns_in  memory operation controls
//   wb_e_in, wb_idx_in           write-back controls
//   mem_req/we/addr/wdata/wmask  memory request (held until mem_ack)
//   mem_rdata, mem_ack           memory response
//   wb_valid/wb_ready            output register handshake
//   wb_e_out, wb_idx_out, wb_val, pc_out  held result
//   MA_fwd_idx, MA_fwd_val, MA_ack  forwarding path to EX
//   err                          one-cycle pulse on misaligned/illegal access
// -----------------------------------------------------------------------------
module pipe_ma
    import pipe_ma_pkg::*;
#(
    parameter int REG_SZ = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       pc_in,
    input  logic [REG_SZ-1:0] ans_in,
    input  logic [REG_SZ-1:0] dat_in,
    input  logic [1:0]        rw_e_in,
    input  logic [1:0]        rw_len_in,
    input  logic              ld_uns_in,
    input  logic              wb_e_in,
    input  logic [4:0]        wb_idx_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic              wb_e_out,
    output logic [4:0]        wb_idx_out,
    output logic [REG_SZ-1:0] wb_val,
    output logic [31:0]       pc_out,
    output logic [4:0]        MA_fwd_idx,
    output logic [31:0]       MA_fwd_val,
    output logic              MA_ack,
    output logic              err
);

    ma_state_e         state_q, state_d;

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wmask_q, mem_wmask_d;

    // Instruction fields kept while the memory operation is outstanding.
    logic [REG_SZ-1:0] op_ans_q, op_ans_d;
    logic [1:0]        op_len_q, op_len_d;
    logic              op_uns_q, op_uns_d;
    logic              op_wb_e_q, op_wb_e_d;
    logic [4:0]        op_idx_q, op_idx_d;
    logic [31:0]       op_pc_q, op_pc_d;

    logic              wb_valid_q, wb_valid_d;
    logic              wb_e_q, wb_e_d;
    logic [4:0]        wb_idx_q, wb_idx_d;
    logic [REG_SZ-1:0] wb_val_q, wb_val_d;
    logic [31:0]       pc_q, pc_d;
    logic              ma_ack_q, ma_ack_d;
    logic              err_q, err_d;

    logic              in_ready_s;
    logic              accept_s;
    logic              fault_s;
    logic [1:0]        lane_addr_s;
    logic [1:0]        lane_len_s;
    logic              lane_uns_s;
    logic [31:0]       lane_wdata_s;
    logic [3:0]        lane_wmask_s;
    logic [REG_SZ-1:0] lane_ld_val_s;

    assign in_ready_s = (state_q == ST_IDLE) && (!wb_valid_q || wb_ready);
    assign accept_s   = in_valid && in_ready_s;
    assign fault_s    = access_fault(rw_e_in, rw_len_in, ans_in[1:0]);

    // One lane helper is shared: in IDLE it shapes the incoming store, in MEM
    // it extracts the load from the latched offset/length.
    always_comb begin
        if (state_q == ST_MEM) begin
            lane_addr_s = op_ans_q[1:0];
            lane_len_s  = op_len_q;
            lane_uns_s  = op_uns_q;
        end else begin
            lane_addr_s = ans_in[1:0];
            lane_len_s  = rw_len_in;
            lane_uns_s  = ld_uns_in;
        end
    end

    ma_lane #(
        .REG_SZ (REG_SZ)
    ) u_lane (
        .addr_lo_i  (lane_addr_s),
        .len_i      (lane_len_s),
        .uns_i      (lane_uns_s),
        .st_data_i  (dat_in[31:0]),
        .ld_rdata_i (mem_rdata),
        .wdata_o    (lane_wdata_s),
        .wmask_o    (lane_wmask_s),
        .ld_val_o   (lane_ld_val_s)
    );

    // Next-state logic for the FSM, memory request and output register.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        op_ans_d    = op_ans_q;
        op_len_d    = op_len_q;
        op_uns_d    = op_uns_q;
        op_wb_e_d   = op_wb_e_q;
        op_idx_d    = op_idx_q;
        op_pc_d     = op_pc_q;
        wb_valid_d  = wb_valid_q;
        wb_e_d      = wb_e_q;
        wb_idx_d    = wb_idx_q;
        wb_val_d    = wb_val_q;
        pc_d        = pc_q;
        ma_ack_d    = 1'b0;
        err_d       = 1'b0;

        // Consumed results drop unless overwritten below on the same edge.
        if (wb_ready) begin
            wb_valid_d = 1'b0;
        end else begin
            wb_valid_d = wb_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (rw_e_in == RW_NONE) begin
                        wb_valid_d = 1'b1;
                        wb_val_d   = ans_in;
                        wb_e_d     = wb_e_in;
                        wb_idx_d   = wb_idx_in;
                        pc_d       = pc_in;
                        ma_ack_d   = wb_e_in && (wb_idx_in != 5'd0);
                    end else if (fault_s) begin
                        // Faulty access retires without touching memory and
                        // never writes the register file.
                        wb_valid_d = 1'b1;
                        wb_val_d   = ans_in;
                        wb_e_d     = 1'b0;
                        wb_idx_d   = wb_idx_in;
                        pc_d       = pc_in;
                        err_d      = 1'b1;
                    end else begin
                        state_d     = ST_MEM;
                        mem_req_d   = 1'b1;
                        mem_we_d    = (rw_e_in == RW_STORE);
                        mem_addr_d  = {ans_in[ADDR_W-1:2], 2'b00};
                        mem_wdata_d = lane_wdata_s;
                        mem_wmask_d = lane_wmask_s;
                        op_ans_d    = ans_in;
                        op_len_d    = rw_len_in;
                        op_uns_d    = ld_uns_in;
                        op_wb_e_d   = wb_e_in;
                        op_idx_d    = wb_idx_in;
                        op_pc_d     = pc_in;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    state_d    = ST_IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_idx_d   = op_idx_q;
                    pc_d       = op_pc_q;
                    if (mem_we_q) begin
                        wb_val_d = op_ans_q;
                        wb_e_d   = 1'b0;
                    end else begin
                        wb_val_d = lane_ld_val_s;
                        wb_e_d   = op_wb_e_q;
                        ma_ack_d = op_wb_e_q && (op_idx_q != 5'd0);
                    end
                end else begin
                    state_d = ST_MEM;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0000_0000;
            mem_wmask_q <= 4'b0000;
            op_ans_q    <= '0;
            op_len_q    <= 2'b00;
            op_uns_q    <= 1'b0;
            op_wb_e_q   <= 1'b0;
            op_idx_q    <= 5'd0;
            op_pc_q     <= 32'h0000_0000;
            wb_valid_q  <= 1'b0;
            wb_e_q      <= 1'b0;
            wb_idx_q    <= 5'd0;
            wb_val_q    <= '0;
            pc_q        <= 32'h0000_0000;
            ma_ack_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            op_ans_q    <= op_ans_d;
            op_len_q    <= op_len_d;
            op_uns_q    <= op_uns_d;
            op_wb_e_q   <= op_wb_e_d;
            op_idx_q    <= op_idx_d;
            op_pc_q     <= op_pc_d;
            wb_valid_q  <= wb_valid_d;
            wb_e_q      <= wb_e_d;
            wb_idx_q    <= wb_idx_d;
            wb_val_q    <= wb_val_d;
            pc_q        <= pc_d;
            ma_ack_q    <= ma_ack_d;
            err_q       <= err_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wmask  = mem_wmask_q;
    assign wb_valid   = wb_valid_q;
    assign wb_e_out   = wb_e_q;
    assign wb_idx_out = wb_idx_q;
    assign wb_val     = wb_val_q;
    assign pc_out     = pc_q;
    // x0 never forwards because its index is already zero.
    assign MA_fwd_idx = (wb_valid_q && wb_e_q) ? wb_idx_q : 5'd0;
    assign MA_fwd_val = wb_val_q[31:0];
    assign MA_ack     = ma_ack_q;
    assign err        = err_q;

endmodule
